// File: rtl/eeprom_arb_pkg.sv
// Shared types, constants and helpers for the EEPROM access arbiter.
// Config word layout: {dev_byte, addr[15:8], addr[7:0], wdata}.
package eeprom_arb_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitDone = 2'd1,
    StTwrWait  = 2'd2
  } arb_state_e;

  // R/W bit appended to the 7-bit device address
  localparam logic DevRwWrite = 1'b0;
  localparam logic DevRwRead  = 1'b1;

  localparam int unsigned CfgDevLsb    = 24;
  localparam int unsigned CfgAddrHiLsb = 16;
  localparam int unsigned CfgAddrLoLsb = 8;
  localparam int unsigned CfgDataLsb   = 0;

  function automatic int unsigned twr_cycles(input int unsigned clk_freq,
                                             input int unsigned twr_us);
    return (clk_freq / 1_000_000) * twr_us;
  endfunction

  function automatic logic [7:0] dev_byte(input logic [6:0] dev_addr, input logic rnw);
    return {dev_addr, (rnw ? DevRwRead : DevRwWrite)};
  endfunction

  function automatic logic [31:0] pack_config(input logic [6:0]  dev_addr,
                                              input logic        rnw,
                                              input logic [15:0] addr,
                                              input logic [7:0]  wdata);
    logic [31:0] cfg;
    cfg = '0;
    cfg[CfgDevLsb +: 8]    = dev_byte(dev_addr, rnw);
    cfg[CfgAddrHiLsb +: 8] = addr[15:8];
    cfg[CfgAddrLoLsb +: 8] = addr[7:0];
    cfg[CfgDataLsb +: 8]   = rnw ? 8'h00 : wdata;
    return cfg;
  endfunction

endpackage

// File: rtl/eeprom_twr_timer.sv
// Loadable down-counter with a zero flag; holds at zero once reached.
// Used for the post-write tWR delay and the optional WAIT_DONE watchdog.
module eeprom_twr_timer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/eeprom_access_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM controller between requesters A and B.
// Define EEPROM_TIMEOUT_EN to add a WAIT_DONE watchdog with a sticky err flag.
module eeprom_access_arbiter
  import eeprom_arb_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned TWR_US      = 5000,
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a_valid,
  input  logic        req_a_rnw,
  input  logic [15:0] req_a_addr,
  input  logic [7:0]  req_a_wdata,
  output logic        req_a_ready,
  output logic        rsp_a_valid,
  output logic [7:0]  rsp_a_rdata,
  input  logic        req_b_valid,
  input  logic        req_b_rnw,
  input  logic [15:0] req_b_addr,
  input  logic [7:0]  req_b_wdata,
  output logic        req_b_ready,
  output logic        rsp_b_valid,
  output logic [7:0]  rsp_b_rdata,
  output logic [31:0] eeprom_config_data,
  output logic        i2c_start,
  input  logic        i2c_done,
  input  logic [7:0]  i2c_rd_data,
  output logic        busy,
  output logic        err
);

  localparam int unsigned TwrCyc  = twr_cycles(CLK_FREQ, TWR_US);
  localparam logic [31:0] TwrLoad = 32'(TwrCyc - 1);
  localparam logic [31:0] ToLoad  = 32'(TIMEOUT_CYC - 1);

  arb_state_e  state_q, state_d;
  logic        last_b_q, last_b_d;    // 1: B was granted last, so A is preferred
  logic        owner_b_q, owner_b_d;
  logic        rnw_q, rnw_d;
  logic [31:0] config_q, config_d;
  logic        start_q, start_d;
  logic        ready_a_q, ready_a_d, ready_b_q, ready_b_d;
  logic        rsp_a_valid_q, rsp_a_valid_d, rsp_b_valid_q, rsp_b_valid_d;
  logic [7:0]  rsp_a_rdata_q, rsp_a_rdata_d, rsp_b_rdata_q, rsp_b_rdata_d;

  logic        grant_b;
  logic        rsp_fire;
  logic [7:0]  rsp_data;
  logic        tmr_load, tmr_en, tmr_zero;
  logic [31:0] tmr_load_val;

`ifdef EEPROM_TIMEOUT_EN
  logic        timeout;
  logic        err_q;
`endif

  eeprom_twr_timer #(
    .Width (32)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    last_b_d     = last_b_q;
    owner_b_d    = owner_b_q;
    rnw_d        = rnw_q;
    config_d     = config_q;
    start_d      = start_q;
    ready_a_d    = 1'b0;
    ready_b_d    = 1'b0;
    rsp_fire     = 1'b0;
    rsp_data     = 8'h00;
    tmr_load     = 1'b0;
    tmr_load_val = TwrLoad;
    tmr_en       = 1'b0;
`ifdef EEPROM_TIMEOUT_EN
    timeout      = 1'b0;
`endif
    grant_b      = req_b_valid && (!req_a_valid || !last_b_q);

    unique case (state_q)
      StIdle: begin
        if (req_a_valid || req_b_valid) begin
          owner_b_d    = grant_b;
          last_b_d     = grant_b;
          rnw_d        = grant_b ? req_b_rnw : req_a_rnw;
          config_d     = grant_b ? pack_config(DEV_ADDR, req_b_rnw, req_b_addr, req_b_wdata)
                                 : pack_config(DEV_ADDR, req_a_rnw, req_a_addr, req_a_wdata);
          start_d      = 1'b1;
          ready_a_d    = !grant_b;
          ready_b_d    = grant_b;
          // Watchdog preload; harmless when the watchdog is not built in
          tmr_load     = 1'b1;
          tmr_load_val = ToLoad;
          state_d      = StWaitDone;
        end
      end
      StWaitDone: begin
        if (i2c_done) begin
          start_d  = 1'b0;
          rsp_fire = 1'b1;
          rsp_data = rnw_q ? i2c_rd_data : 8'h00;
          if (rnw_q) begin
            state_d = StIdle;
          end else begin
            tmr_load = 1'b1;
            state_d  = StTwrWait;
          end
        end
`ifdef EEPROM_TIMEOUT_EN
        else if (tmr_zero) begin
          start_d  = 1'b0;
          rsp_fire = 1'b1;
          rsp_data = 8'hFF;
          timeout  = 1'b1;
          state_d  = StIdle;
        end else begin
          tmr_en = 1'b1;
        end
`endif
      end
      StTwrWait: begin
        if (tmr_zero) begin
          state_d = StIdle;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    rsp_a_valid_d = rsp_fire && !owner_b_q;
    rsp_b_valid_d = rsp_fire && owner_b_q;
    rsp_a_rdata_d = rsp_a_valid_d ? rsp_data : rsp_a_rdata_q;
    rsp_b_rdata_d = rsp_b_valid_d ? rsp_data : rsp_b_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_b_q      <= 1'b1;
      owner_b_q     <= 1'b0;
      rnw_q         <= 1'b0;
      config_q      <= '0;
      start_q       <= 1'b0;
      ready_a_q     <= 1'b0;
      ready_b_q     <= 1'b0;
      rsp_a_valid_q <= 1'b0;
      rsp_b_valid_q <= 1'b0;
      rsp_a_rdata_q <= 8'h00;
      rsp_b_rdata_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      last_b_q      <= last_b_d;
      owner_b_q     <= owner_b_d;
      rnw_q         <= rnw_d;
      config_q      <= config_d;
      start_q       <= start_d;
      ready_a_q     <= ready_a_d;
      ready_b_q     <= ready_b_d;
      rsp_a_valid_q <= rsp_a_valid_d;
      rsp_b_valid_q <= rsp_b_valid_d;
      rsp_a_rdata_q <= rsp_a_rdata_d;
      rsp_b_rdata_q <= rsp_b_rdata_d;
    end
  end

`ifdef EEPROM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign req_a_ready        = ready_a_q;
  assign req_b_ready        = ready_b_q;
  assign rsp_a_valid        = rsp_a_valid_q;
  assign rsp_b_valid        = rsp_b_valid_q;
  assign rsp_a_rdata        = rsp_a_rdata_q;
  assign rsp_b_rdata        = rsp_b_rdata_q;
  assign eeprom_config_data = config_q;
  assign i2c_start          = start_q;
  assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Self-checking bench for eeprom_access_arbiter: vector table plus multi-cycle sequences,
// with a response scoreboard. Build with EEPROM_TIMEOUT_EN to include the watchdog sequence.
module tb_eeprom_access_arbiter;

  logic        clk, rst_n;
  logic        req_a_valid, req_a_rnw, req_a_ready, rsp_a_valid;
  logic [15:0] req_a_addr;
  logic [7:0]  req_a_wdata, rsp_a_rdata;
  logic        req_b_valid, req_b_rnw, req_b_ready, rsp_b_valid;
  logic [15:0] req_b_addr;
  logic [7:0]  req_b_wdata, rsp_b_rdata;
  logic [31:0] eeprom_config_data;
  logic        i2c_start, i2c_done, busy, err;
  logic [7:0]  i2c_rd_data;

  eeprom_access_arbiter #(
    .CLK_FREQ    (50_000_000),
    .TWR_US      (2),
    .DEV_ADDR    (7'h50),
    .TIMEOUT_CYC (200)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_a_valid        (req_a_valid),
    .req_a_rnw          (req_a_rnw),
    .req_a_addr         (req_a_addr),
    .req_a_wdata        (req_a_wdata),
    .req_a_ready        (req_a_ready),
    .rsp_a_valid        (rsp_a_valid),
    .rsp_a_rdata        (rsp_a_rdata),
    .req_b_valid        (req_b_valid),
    .req_b_rnw          (req_b_rnw),
    .req_b_addr         (req_b_addr),
    .req_b_wdata        (req_b_wdata),
    .req_b_ready        (req_b_ready),
    .rsp_b_valid        (rsp_b_valid),
    .rsp_b_rdata        (rsp_b_rdata),
    .eeprom_config_data (eeprom_config_data),
    .i2c_start          (i2c_start),
    .i2c_done           (i2c_done),
    .i2c_rd_data        (i2c_rd_data),
    .busy               (busy),
    .err                (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       who_b;
    logic [7:0] rdata;
  } exp_t;

  typedef struct {
    bit          who_b;
    bit          rnw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mdl_rd;
    logic [31:0] cfg;
    logic [7:0]  exp_rdata;
    int          busy_after;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rsp = 0;
  int   last_start_len = 0;

  // Controller model: done pulse 40 cycles after start rises; read byte = addr[7:0] ^ key
  logic       model_en;
  logic [7:0] mdl_key;
  int         mdl_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_cnt  <= 0;
      i2c_done <= 1'b0;
    end else begin
      i2c_done <= 1'b0;
      if (i2c_start && !i2c_done && model_en) begin
        if (mdl_cnt == 38) begin
          i2c_done <= 1'b1;
          mdl_cnt  <= 0;
        end else begin
          mdl_cnt <= mdl_cnt + 1;
        end
      end else begin
        mdl_cnt <= 0;
      end
    end
  end

  assign i2c_rd_data = eeprom_config_data[15:8] ^ mdl_key;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor and scoreboard
  initial begin
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
      end else begin
        if (i2c_start) run++;
        else if (run != 0) begin
          last_start_len = run;
          run = 0;
        end
        if (rsp_a_valid || rsp_b_valid) begin
          n_rsp++;
          check("gap_start_low", 32'(i2c_start), 32'd0);
          if (sb_q.size() == 0) begin
            check("rsp_unexpected", 32'({rsp_a_valid, rsp_b_valid}), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("rsp_owner", 32'({rsp_a_valid, rsp_b_valid}), e.who_b ? 32'd1 : 32'd2);
            check("rsp_rdata", 32'(e.who_b ? rsp_b_rdata : rsp_a_rdata), 32'(e.rdata));
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic set_req(input bit who_b, input bit valid, input bit rnw,
                         input logic [15:0] addr, input logic [7:0] wdata);
    if (who_b) begin
      req_b_valid = valid; req_b_rnw = rnw; req_b_addr = addr; req_b_wdata = wdata;
    end else begin
      req_a_valid = valid; req_a_rnw = rnw; req_a_addr = addr; req_a_wdata = wdata;
    end
  endtask

  task automatic wait_ready(input bit who_b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (who_b ? req_b_ready : req_a_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("ready_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input bit who_b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (who_b ? rsp_b_valid : rsp_a_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("rsp_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v;
    int   nb, t, g, ia, ib, rsp_before;
    bit   got_b;

    vecs[0] = '{1'b0, 1'b0, 16'h000F, 8'h0F, 8'h3C, 32'hA0000F0F, 8'h00, 100};
    vecs[1] = '{1'b1, 1'b1, 16'h000F, 8'h00, 8'h5A, 32'hA1000F00, 8'h5A, 0};
    vecs[2] = '{1'b0, 1'b1, 16'h1234, 8'h77, 8'hC3, 32'hA1123400, 8'hC3, 0};
    vecs[3] = '{1'b1, 1'b0, 16'hABCD, 8'h96, 8'h11, 32'hA0ABCD96, 8'h00, 100};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 8'h81, 32'hA1FFFF00, 8'h81, 0};

    rst_n    = 1'b0;
    model_en = 1'b1;
    mdl_key  = 8'h00;
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({i2c_start, busy, err, req_a_ready, req_b_ready,
                           rsp_a_valid, rsp_b_valid}), 32'd0);
    check("rst_config", eeprom_config_data, 32'd0);
    check("rst_rdata", 32'({rsp_a_rdata, rsp_b_rdata}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single transactions from the vector table
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      mdl_key = v.addr[7:0] ^ v.mdl_rd;
      sb_q.push_back(exp_t'{who_b: v.who_b, rdata: v.exp_rdata});
      set_req(v.who_b, 1'b1, v.rnw, v.addr, v.wdata);
      wait_ready(v.who_b);
      check("vec_cfg", eeprom_config_data, v.cfg);
      check("vec_start_busy", 32'({i2c_start, busy}), 32'd3);
      @(posedge clk); #1 set_req(v.who_b, 1'b0, 1'b0, 16'h0, 8'h0);
      @(negedge clk);
      check("ready_one_cycle", 32'(v.who_b ? req_b_ready : req_a_ready), 32'd0);
      check("cfg_stable", eeprom_config_data, v.cfg);
      wait_rsp(v.who_b);
      nb = 0;
      while (busy && nb < 300) begin
        nb++;
        @(negedge clk);
      end
      check("vec_busy_after", 32'(nb), 32'(v.busy_after));
      @(negedge clk);
      check("vec_start_len", 32'(last_start_len), 32'd40);
    end
`ifndef EEPROM_TIMEOUT_EN
    check("err_tied_low", 32'(err), 32'd0);
`endif

    // Round robin: both requesters hold three reads each, starting from reset (A preferred)
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    mdl_key = 8'h00;
    ia = 0; ib = 0; g = 0;
    set_req(1'b0, 1'b1, 1'b1, 16'h0010, 8'hEE);
    set_req(1'b1, 1'b1, 1'b1, 16'h0020, 8'hEE);
    for (int cyc = 0; cyc < 2000 && g < 6; cyc++) begin
      @(negedge clk);
      if (req_a_ready || req_b_ready) begin
        got_b = req_b_ready;
        check("rr_both_ready", 32'(req_a_ready && req_b_ready), 32'd0);
        check("rr_order", 32'(got_b), 32'(g % 2));
        check("rr_cfg", eeprom_config_data,
              got_b ? {8'hA1, 16'h0020 + 16'(ib), 8'h00} : {8'hA1, 16'h0010 + 16'(ia), 8'h00});
        sb_q.push_back(exp_t'{who_b: got_b, rdata: got_b ? 8'h20 + 8'(ib) : 8'h10 + 8'(ia)});
        g++;
        @(posedge clk); #1;
        if (got_b) begin
          ib++;
          if (ib == 3) set_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
          else set_req(1'b1, 1'b1, 1'b1, 16'h0020 + 16'(ib), 8'hEE);
        end else begin
          ia++;
          if (ia == 3) set_req(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
          else set_req(1'b0, 1'b1, 1'b1, 16'h0010 + 16'(ia), 8'hEE);
        end
      end
    end
    check("rr_grants", 32'(g), 32'd6);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check("rr_drain", 32'(sb_q.size()), 32'd0);

    // B requests during A's tWR hold-off
    @(negedge clk);
    sb_q.push_back(exp_t'{who_b: 1'b0, rdata: 8'h00});
    set_req(1'b0, 1'b1, 1'b0, 16'h0100, 8'hAB);
    wait_ready(1'b0);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    wait_rsp(1'b0);
    @(posedge clk); #1 set_req(1'b1, 1'b1, 1'b1, 16'h0200, 8'h00);
    sb_q.push_back(exp_t'{who_b: 1'b1, rdata: 8'h00});
    t = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      t++;
      if (req_b_ready) break;
    end
    check("twr_ready_latency", 32'(t), 32'd101);
    @(posedge clk); #1 set_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    wait_rsp(1'b1);
    @(negedge clk);

    // Reset in the middle of WAIT_DONE loses the request silently
    set_req(1'b0, 1'b1, 1'b1, 16'h0300, 8'h00);
    wait_ready(1'b0);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_outputs", 32'({i2c_start, busy, rsp_a_valid, rsp_b_valid}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_before = n_rsp;
    repeat (80) @(negedge clk);
    check("rst_mid_no_rsp", 32'(n_rsp), 32'(rsp_before));
    check("rst_mid_idle", 32'({busy, i2c_start}), 32'd0);

`ifdef EEPROM_TIMEOUT_EN
    // Controller never answers: watchdog fires after 200 cycles
    model_en = 1'b0;
    sb_q.push_back(exp_t'{who_b: 1'b0, rdata: 8'hFF});
    set_req(1'b0, 1'b1, 1'b1, 16'h0400, 8'h00);
    wait_ready(1'b0);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    wait_rsp(1'b0);
    check("to_err_set", 32'(err), 32'd1);
    @(negedge clk);
    check("to_start_len", 32'(last_start_len), 32'd200);
    check("to_idle", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("to_err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check("to_err_reset", 32'(err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_en = 1'b1;
`endif

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
